tff_count_monitor: RTL



---
 rtl/tff_count_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tff_count_monitor.sv
// rtl/tff_count_monitor.sv - sequence checker, wrap/fault counters and 7-seg digit for a 3-bit T-FF counter
module tff_count_monitor #(
  parameter int DIR         = 0,
  parameter int LOCK_LEN    = 2,
  parameter int WRAP_W      = 8,
  parameter int ERR_W       = 4,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              Ta,
  input  logic              Tb,
  input  logic              Tc,
  input  logic              CLR_ERR,
  output logic [6:0]        SEG,
  output logic              LOCKED,
  output logic              WRAP,
  output logic [WRAP_W-1:0] WRAP_CNT,
  output logic              ERR,
  output logic [ERR_W-1:0]  ERR_CNT
);

  typedef enum logic [1:0] {S_SYNC, S_ACQ, S_TRACK} state_t;

  localparam logic [2:0] LOCK_N    = 3'(LOCK_LEN);
  localparam logic [6:0] SEG_BLANK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  state_t              state_q, state_d;
  logic [2:0]          prev_q, prev_d;
  logic [2:0]          match_q, match_d;
  logic                wrap_q, wrap_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [6:0]          seg_q, seg_d;

  logic [2:0]          cur;
  logic [2:0]          exp_val;
  logic                is_wrap;
  logic                fault;

  // Digit patterns are {g,f,e,d,c,b,a}, active-high; 7 lights only a,b,c.
  function automatic logic [6:0] seg_decode(input logic [2:0] v);
    case (v)
      3'd0:    seg_decode = 7'h3F;
      3'd1:    seg_decode = 7'h06;
      3'd2:    seg_decode = 7'h5B;
      3'd3:    seg_decode = 7'h4F;
      3'd4:    seg_decode = 7'h66;
      3'd5:    seg_decode = 7'h6D;
      3'd6:    seg_decode = 7'h7D;
      default: seg_decode = 7'h07;
    endcase
  endfunction

  assign cur     = {Tc, Tb, Ta};
  assign exp_val = (DIR != 0) ? (prev_q - 3'd1) : (prev_q + 3'd1);
  assign is_wrap = (DIR != 0) ? (prev_q == 3'd0 && cur == 3'd7)
                              : (prev_q == 3'd7 && cur == 3'd0);

  // Next-state: sequence FSM, wrap/fault bookkeeping and display load on each sample
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = match_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    seg_d      = seg_q;
    fault      = 1'b0;

    if (EN) begin
      prev_d = cur;
      seg_d  = (SEG_ACT_LOW != 0) ? ~seg_decode(cur) : seg_decode(cur);
      case (state_q)
        S_SYNC: begin
          match_d = 3'd0;
          state_d = S_ACQ;
        end
        S_ACQ: begin
          if (cur == exp_val) begin
            match_d = match_q + 3'd1;
            if (match_q + 3'd1 == LOCK_N) state_d = S_TRACK;
          end else begin
            match_d = 3'd0;
          end
        end
        S_TRACK: begin
          if (cur == exp_val) begin
            if (is_wrap) begin
              wrap_d = 1'b1;
              if (!(&wrap_cnt_q)) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end
          end else begin
            fault   = 1'b1;
            match_d = 3'd0;
            state_d = S_ACQ;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end

    // A fault on the same edge as a clear leaves exactly one recorded fault.
    if (fault) begin
      err_d = 1'b1;
      if (CLR_ERR)           err_cnt_d = ERR_W'(1);
      else if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end else if (CLR_ERR) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_SYNC;
      prev_q     <= 3'd0;
      match_q    <= 3'd0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      seg_q      <= seg_d;
    end
  end

  assign SEG      = seg_q;
  assign LOCKED   = (state_q == S_TRACK);
  assign WRAP     = wrap_q;
  assign WRAP_CNT = wrap_cnt_q;
  assign ERR      = err_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
